// File: rtl/halut_decoder.sv
// HALUT decoder: per-column LUT lookup and accumulation over C codebook indices.
// Define HALUT_DECODER_SAT_EN to clamp the result instead of wrapping it.
module halut_decoder #(
  parameter int unsigned K             = 16,
  parameter int unsigned C             = 32,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned AccWidth      = DataTypeWidth + $clog2(C)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     lut_wr_en_i,
  input  logic [$clog2(C*K)-1:0]   lut_wr_addr_i,
  input  logic [DataTypeWidth-1:0] lut_wr_data_i,
  input  logic                     enc_valid_i,
  output logic                     enc_ready_o,
  input  logic [$clog2(K)-1:0]     enc_k_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [DataTypeWidth-1:0] res_data_o,
  output logic                     busy_o
);

  localparam int unsigned CW   = $clog2(C);
  localparam int unsigned AW   = $clog2(C * K);
  localparam int unsigned ExtW = AccWidth - DataTypeWidth;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StOut
  } state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              c_cnt_q, c_cnt_d;
  logic [AccWidth-1:0]        acc_q, acc_d;
  logic                       rd_vld_q, rd_vld_d;
  logic                       rd_first_q, rd_first_d;
  logic                       acc_vld_q, acc_vld_d;
  logic                       res_valid_q, res_valid_d;
  logic [DataTypeWidth-1:0]   res_data_q, res_data_d;

  logic [DataTypeWidth-1:0]   lut_mem [C*K];
  logic [DataTypeWidth-1:0]   lut_q;
  logic [AW-1:0]              rd_addr;
  logic [AccWidth-1:0]        lut_ext;
  logic [DataTypeWidth-1:0]   acc_conv;
  logic                       enc_hs;

  assign enc_ready_o = (state_q == StAccum);
  assign enc_hs      = enc_valid_i & enc_ready_o;
  assign rd_addr     = AW'(32'(c_cnt_q) * K + 32'(enc_k_i));
  assign lut_ext     = {{ExtW{lut_q[DataTypeWidth-1]}}, lut_q};

  // Nonblocking write and read in one block: a same-address collision reads old data.
  always_ff @(posedge clk_i) begin
    if (lut_wr_en_i) begin
      lut_mem[lut_wr_addr_i] <= lut_wr_data_i;
    end
    if (enc_hs) begin
      lut_q <= lut_mem[rd_addr];
    end
  end

  always_comb begin
`ifdef HALUT_DECODER_SAT_EN
    if ((&acc_q[AccWidth-1:DataTypeWidth-1]) || !(|acc_q[AccWidth-1:DataTypeWidth-1])) begin
      acc_conv = acc_q[DataTypeWidth-1:0];
    end else if (acc_q[AccWidth-1]) begin
      acc_conv = {1'b1, {(DataTypeWidth-1){1'b0}}};
    end else begin
      acc_conv = {1'b0, {(DataTypeWidth-1){1'b1}}};
    end
`else
    acc_conv = acc_q[DataTypeWidth-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    c_cnt_d     = c_cnt_q;
    acc_d       = acc_q;
    rd_vld_d    = 1'b0;
    rd_first_d  = rd_first_q;
    acc_vld_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    // Accumulate stage; the first lookup of a column overwrites the stale sum.
    if (rd_vld_q) begin
      acc_d     = rd_first_q ? lut_ext : acc_q + lut_ext;
      acc_vld_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StAccum;
      end
      StAccum: begin
        if (enc_hs) begin
          rd_vld_d   = 1'b1;
          rd_first_d = (c_cnt_q == '0);
          if (c_cnt_q == CW'(C - 1)) begin
            c_cnt_d = '0;
            state_d = StDrain;
          end else begin
            c_cnt_d = c_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!rd_vld_q && !acc_vld_q) begin
          res_valid_d = 1'b1;
          res_data_d  = acc_conv;
          state_d     = StOut;
        end
      end
      StOut: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = StAccum;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      c_cnt_q     <= '0;
      acc_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      acc_vld_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      c_cnt_q     <= c_cnt_d;
      acc_q       <= acc_d;
      rd_vld_q    <= rd_vld_d;
      rd_first_q  <= rd_first_d;
      acc_vld_q   <= acc_vld_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign busy_o      = (state_q != StIdle) &&
                       ((c_cnt_q != '0) || rd_vld_q || acc_vld_q || res_valid_q);

endmodule

// File: tb/tb_halut_decoder.sv
// Table-driven bench for halut_decoder with a result scoreboard queue.
// Expected values follow HALUT_DECODER_SAT_EN when it is defined.
module tb_halut_decoder;

  localparam int K   = 16;
  localparam int C   = 32;
  localparam int DTW = 16;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           lut_wr_en_i;
  logic [8:0]     lut_wr_addr_i;
  logic [DTW-1:0] lut_wr_data_i;
  logic           enc_valid_i;
  logic           enc_ready_o;
  logic [3:0]     enc_k_i;
  logic           res_valid_o;
  logic           res_ready_i;
  logic [DTW-1:0] res_data_o;
  logic           busy_o;

  halut_decoder dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .lut_wr_en_i   (lut_wr_en_i),
    .lut_wr_addr_i (lut_wr_addr_i),
    .lut_wr_data_i (lut_wr_data_i),
    .enc_valid_i   (enc_valid_i),
    .enc_ready_o   (enc_ready_o),
    .enc_k_i       (enc_k_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_data_o    (res_data_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DTW-1:0] exp_q[$];
  logic prev_valid = 1'b0;

  typedef struct {
    int          fill;
    int          kmode;
    bit          gaps;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] sel(input logic [15:0] w, input logic [15:0] s);
`ifdef HALUT_DECODER_SAT_EN
    return s;
`else
    return w;
`endif
  endfunction

  function automatic logic [15:0] lut_val(input int mode, input int c, input int k);
    case (mode)
      0:       return (k == 0) ? 16'd1 : 16'd0;
      1:       return 16'(c + k);
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'hFFFD;
      default: return 16'(-1000 * c);
    endcase
  endfunction

  function automatic logic [3:0] k_of(input int kmode, input int c);
    case (kmode)
      0:       return 4'd0;
      1:       return 4'(c % 16);
      3:       return 4'd5;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // Scoreboard: compare each result once, when res_valid_o rises.
  always @(negedge clk) begin
    if (res_valid_o && !prev_valid) begin
      if (exp_q.size() == 0) check("result expected by scoreboard", 32'(exp_q.size()), 1);
      else check("result data", 32'(res_data_o), 32'(exp_q.pop_front()));
    end
    prev_valid <= res_valid_o;
  end

  task automatic fill_lut(input int mode);
    for (int c = 0; c < C; c++) begin
      for (int k = 0; k < K; k++) begin
        lut_wr_en_i   = 1'b1;
        lut_wr_addr_i = 9'(c * K + k);
        lut_wr_data_i = lut_val(mode, c, k);
        @(negedge clk);
      end
    end
    lut_wr_en_i = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!enc_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check({name, " enc_ready timeout"}, 32'(enc_ready_o), 1);
  endtask

  task automatic run_column(input int kmode, input bit gaps, input bit collide, input int bp,
                            input logic [15:0] exp, input string name);
    int          lat;
    logic [15:0] held;
    logic [3:0]  k;
    res_ready_i = (bp == 0);
    exp_q.push_back(exp);
    for (int c = 0; c < C; c++) begin
      if (gaps && c[0]) begin
        enc_valid_i = 1'b0;
        @(negedge clk);
      end
      k           = k_of(kmode, c);
      enc_valid_i = 1'b1;
      enc_k_i     = k;
      wait_ready(name);
      if (collide) begin
        lut_wr_en_i   = 1'b1;
        lut_wr_addr_i = 9'(c * K + int'(k));
        lut_wr_data_i = 16'h1000;
      end
      @(negedge clk);
      lut_wr_en_i = 1'b0;
    end
    enc_valid_i = 1'b0;
    lat = 0;
    while (!res_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 3);
    check({name, " enc_ready low in OUT"}, 32'(enc_ready_o), 0);
    if (bp > 0) begin
      held = res_data_o;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        check({name, " bp data stable"}, 32'(res_data_o), 32'(held));
        check({name, " bp valid held"}, 32'(res_valid_o), 1);
        check({name, " bp enc_ready low"}, 32'(enc_ready_o), 0);
      end
      res_ready_i = 1'b1;
    end
    @(negedge clk);
    check({name, " valid dropped"}, 32'(res_valid_o), 0);
    check({name, " next column ready"}, 32'(enc_ready_o), 1);
  endtask

  initial begin
    vecs[0] = '{0, 0, 1'b0, 16'd32,   16'd32,   "basic"};
    vecs[1] = '{1, 1, 1'b0, 16'd736,  16'd736,  "index select"};
    vecs[2] = '{1, 1, 1'b1, 16'd736,  16'd736,  "index select gaps"};
    vecs[3] = '{2, 2, 1'b1, 16'hFFE0, 16'h7FFF, "pos overflow"};
    vecs[4] = '{3, 2, 1'b0, 16'h0000, 16'h8000, "neg overflow"};
    vecs[5] = '{4, 3, 1'b1, 16'hFFA0, 16'hFFA0, "negative sum"};
    vecs[6] = '{5, 2, 1'b0, 16'h6E80, 16'h8000, "large negative"};

    rst_i         = 1'b1;
    lut_wr_en_i   = 1'b0;
    lut_wr_addr_i = '0;
    lut_wr_data_i = '0;
    enc_valid_i   = 1'b0;
    enc_k_i       = '0;
    res_ready_i   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset res_valid", 32'(res_valid_o), 0);
    check("reset enc_ready", 32'(enc_ready_o), 0);
    check("reset res_data", 32'(res_data_o), 0);
    check("reset busy", 32'(busy_o), 0);
    rst_i = 1'b0;
    check("idle enc_ready", 32'(enc_ready_o), 0);
    @(negedge clk);
    check("accum after reset", 32'(enc_ready_o), 1);

    for (int v = 0; v < 7; v++) begin
      fill_lut(vecs[v].fill);
      run_column(vecs[v].kmode, vecs[v].gaps, 1'b0, 0,
                 sel(vecs[v].exp_wrap, vecs[v].exp_sat), vecs[v].name);
    end

    // Same-cycle write to the address being read: old values feed the sum.
    fill_lut(1);
    run_column(1, 1'b1, 1'b1, 0, 16'd736, "collision old data");
    run_column(1, 1'b0, 1'b0, 0, sel(16'h0000, 16'h7FFF), "collision new data");

    fill_lut(1);
    run_column(1, 1'b0, 1'b0, 5, 16'd736, "backpressure");

    // Reset part-way through a column: nothing emitted, next column is clean.
    for (int c = 0; c < 10; c++) begin
      enc_valid_i = 1'b1;
      enc_k_i     = 4'(c % 16);
      wait_ready("partial");
      @(negedge clk);
    end
    enc_valid_i = 1'b0;
    check("busy mid column", 32'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    check("mid reset res_valid", 32'(res_valid_o), 0);
    check("mid reset enc_ready", 32'(enc_ready_o), 0);
    check("mid reset res_data", 32'(res_data_o), 0);
    check("mid reset busy", 32'(busy_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    run_column(1, 1'b0, 1'b0, 0, 16'd736, "post reset");

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/halut_decoder.md
Name: halut_decoder

Overview:
- Consumer side of the HALUT encoder stream.
- Takes one 4-bit prototype index per codebook, in codebook order c = 0..C-1, for a single output column.
- Looks up each index in a local LUT of signed DataTypeWidth entries and accumulates the C lookups into one result.
- Hands the result downstream on a valid/ready port.
- Instantiated DecoderUnits times next to the encoder, one per output column M.

Parameters:
- K, 16, prototypes per codebook; index width KW = $clog2(K) = 4.
- C, 32, codebooks per input row; counter width CW = $clog2(C).
- DataTypeWidth, 16, signed two's-complement width of LUT entries and of the result.
- AccWidth, DataTypeWidth + $clog2(C), internal accumulator width; cannot overflow.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- lut_wr_en_i  in  1  LUT write strobe.
- lut_wr_addr_i  in  $clog2(C*K)  write address = c*K + k.
- lut_wr_data_i  in  DataTypeWidth  signed LUT entry.
- enc_valid_i  in  1  encoded index valid.
- enc_ready_o  out  1  decoder accepts an index.
- enc_k_i  in  KW  prototype index for the current codebook.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  downstream accepts the result.
- res_data_o  out  DataTypeWidth  column result.
- busy_o  out  1  high when state != IDLE and (c_cnt != 0 or pipeline non-empty or res_valid_o).

Behaviour:
- Reset values:
  - state = IDLE, c_cnt = 0, acc = 0.
  - Read pipeline valid bits = 0.
  - enc_ready_o = 0, res_valid_o = 0, res_data_o = 0, busy_o = 0.
  - LUT contents are not reset.
- States:
  - IDLE -> ACCUM unconditionally, on the first clock after reset release.
  - ACCUM: enc_ready_o = 1. A handshake (enc_valid_i & enc_ready_o) issues a LUT read at address c_cnt*K + enc_k_i, then increments c_cnt. The handshake at c_cnt == C-1 wraps c_cnt to 0 and moves to DRAIN.
  - DRAIN: enc_ready_o = 0. Waits until both read-pipeline stages are empty, then sets res_valid_o and moves to OUT.
  - OUT: enc_ready_o = 0. res_data_o and res_valid_o are held stable until res_ready_i = 1. On that handshake: acc cleared, res_valid_o dropped, move to ACCUM.
- Pipeline:
  - Stage 1: registered synchronous LUT read.
  - Stage 2: acc += sign_extend(lut_q) to AccWidth.
  - The first lookup of a column replaces acc instead of adding to it.
  - Full throughput: one index per cycle in ACCUM. Gaps in enc_valid_i simply insert bubbles.
- Latency: res_valid_o rises 3 cycles after the clock edge that accepts index C-1 (read, accumulate, output register).
- The next column's first index is accepted in the cycle after the result handshake.
- LUT write/read collision (same address, same cycle): the read returns the old data.
- Writes are accepted in every state. Software must not rewrite the LUT mid-column if it needs consistent results.
- Reset mid-column: the partial sum is discarded, c_cnt returns to 0, and no result is emitted.
- Output conversion of acc (AccWidth) to res_data_o (DataTypeWidth) is defined by the optional feature below.

Optional Feature:
- Macro: HALUT_DECODER_SAT_EN.
- Defined: res_data_o = acc clamped to the signed DataTypeWidth range, i.e. [-2^(DataTypeWidth-1), 2^(DataTypeWidth-1)-1].
- Undefined: res_data_o = acc[DataTypeWidth-1:0] (two's-complement wrap).
- No other behaviour changes.

Test Plan:
- Basic sum: write LUT[c][0] = 1 for all c; send 32 indices k = 0 back-to-back with res_ready_i = 1 -> res_data_o = 32, res_valid_o asserted 3 cycles after the last handshake, held 1 cycle.
- Index select: LUT[c][k] = c + k; send k = c mod 16 -> result = sum over c of (c + (c mod 16)) = 496 + 240 = 736.
- Backpressure: hold res_ready_i = 0 for 5 cycles after res_valid_o -> res_data_o stable, enc_ready_o = 0 throughout; the next column starts the cycle after res_ready_i = 1.
- Overflow: all entries 0x7FFF -> SAT_EN gives 0x7FFF, without it 0xFFE0. All entries 0x8000 -> SAT_EN gives 0x8000, without it 0x0000.
- Stall/collision: enc_valid_i toggling 1/0 with a write to the address being read in the same cycle -> old value used in the sum; result equals the expected total computed with the old values.
- Reset mid-operation: assert rst_i after 10 indices -> all outputs 0 immediately. After release, a full 32-index column yields only that column's sum.
